pack_recv: RTL
==============

Name: pack_recv

Overview:
- Receive-side deframer for the orbtrace byte stream: takes bytes from the serial/USB side, hunts for the FF FF FF 7F sync sequence and rebuilds 16-byte trace frames as 8 little-endian 16-bit words.
- Presents the frames on a packet-buffer interface: PacketAvail / PacketNext / PacketNextWd / PacketOut.
- Sits between the byte link and the host-side frame consumer (loopback checking, bridge).

Parameters:
- FRAMES, 4, frame slots buffered; power of 2, range 2..16.
- OVF_STRETCH, 2047, cycles the Overflow output is held high after a drop; counter width 11 bits.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-low
- DataIn  in  8  received byte
- DataValid  in  1  one-cycle strobe; DataIn is valid this cycle
- ResyncReq  in  1  one-cycle strobe; forces loss of sync
- InSync  out  1  high while framed
- PacketAvail  out  1  at least one complete, unclaimed frame buffered
- PacketNext  in  1  one-cycle strobe; release the held frame, claim the oldest complete frame
- PacketNextWd  in  1  one-cycle strobe; advance to the next word of the held frame
- PacketOut  out  16  current word; low byte = earlier-received byte
- Overflow  out  1  stretched frame-drop indicator
- DropCount  out  16  frames dropped (feature-dependent)
- SyncCount  out  16  sync sequences recognised (feature-dependent)

Behaviour:
- Reset (rst==0 at posedge):
  - all outputs 0; state HUNT; buffer empty; no frame held; byte index 0.
  - Counters and stretch cleared.
- Storage: FRAMES x 8 words.
  - A byte at an even index is latched in a low-byte register.
  - A byte at an odd index writes {DataIn, lowreg} to the current slot at word index/2.
- States, advancing only on DataValid:
  - HUNT: a sync matcher tracks the last 4 bytes. On FF FF FF 7F: go to RX with index 0, set InSync=1, increment SyncCount. A byte other than FF or 7F clears the match. Extra leading FFs are tolerated, e.g. FF FF FF FF 7F matches.
  - RX: store the byte, index+1.
    - If index reaches 4 and bytes 0..3 were FF FF FF 7F: treat as inter-frame sync. Index goes to 0, the slot is not committed, SyncCount increments.
    - A sync pattern at any other index is plain data.
    - On index 15: commit the frame if committed-frame count (held + unclaimed) < FRAMES. Otherwise drop it, increment DropCount, load the stretch counter with OVF_STRETCH. Index goes to 0 either way.
- ResyncReq: takes priority over DataValid in the same cycle.
  - Discard the partial frame, go to HUNT, InSync=0.
  - Committed frames are kept.
- Full check uses the registered count. A commit and a PacketNext release in the same cycle while full still drops the frame.
- Read side:
  - PacketNext: frees the held frame if any. If a complete frame exists, claims the oldest, word index 0. If none exists, nothing is held.
  - PacketAvail = unclaimed complete frames > 0, registered; updated the cycle after a commit or claim.
  - PacketOut = mem[held][wordidx], registered; valid 1 cycle after the PacketNext or PacketNextWd strobe.
  - PacketNextWd increments wordidx mod 8. It is ignored when nothing is held.
  - A simultaneous PacketNext and PacketNextWd: PacketNext wins.
- Pointers wrap modulo FRAMES.
- Overflow = (stretch != 0), registered. Stretch decrements to 0.
- Counters saturate at FFFF.

Optional Feature:
- PACK_RECV_STATS_EN
  - Defined: DropCount and SyncCount count as specified.
  - Undefined: both are tied to 0 and the counter logic is omitted. Frame and Overflow behaviour is unchanged.

Test Plan:
- Reset, then FF FF FF 7F followed by bytes 00..0F -> InSync=1; PacketAvail=1; PacketNext gives PacketOut=0x0100. Seven PacketNextWd strobes step to 0x0302 … 0x0F0E, then wrap to 0x0100.
- FF FF FF 7F, frame A, FF FF FF 7F, frame B -> exactly 2 frames are available. SyncCount=2 (STATS_EN). The sync bytes never appear in PacketOut.
- Send FRAMES+1 = 5 frames with no reads -> PacketAvail=1; frame 5 is dropped; Overflow high for 2047 cycles; DropCount=1. A following PacketNext holds frame 1.
- ResyncReq after 7 bytes of a frame, then bytes without sync -> InSync=0, nothing committed. After FF FF FF 7F plus 16 bytes, one frame is committed.
- Commit completes in the same cycle as PacketNext with 4 committed frames -> the new frame is dropped, the held frame is released, the count goes to 3.
- Assert rst low mid-frame with 2 frames buffered -> all outputs 0, the buffer is empty, and a fresh sync is required.

Source files
------------

// File: rtl/pack_recv.sv
// pack_recv: receive-side deframer for the orbtrace byte stream.
// Hunts for the FF FF FF 7F sync sequence, rebuilds 16-byte frames as
// 8 little-endian 16-bit words and buffers up to FRAMES of them for the
// PacketAvail / PacketNext / PacketNextWd / PacketOut reader.
// Optional feature macro: PACK_RECV_STATS_EN enables the DropCount and
// SyncCount statistics; when undefined both outputs are tied to zero.
module pack_recv #(
  parameter int FRAMES      = 4,     // frame slots, power of 2, 2..16
  parameter int OVF_STRETCH = 2047   // cycles Overflow stays high after a drop
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  DataIn,
  input  logic        DataValid,
  input  logic        ResyncReq,
  output logic        InSync,
  output logic        PacketAvail,
  input  logic        PacketNext,
  input  logic        PacketNextWd,
  output logic [15:0] PacketOut,
  output logic        Overflow,
  output logic [15:0] DropCount,
  output logic [15:0] SyncCount
);

  localparam int PW = $clog2(FRAMES);
  localparam int CW = PW + 1;

  typedef enum logic {
    HUNT = 1'b0,
    RX   = 1'b1
  } state_t;

  state_t          state, stateNext;
  logic [3:0]      byteIdx, byteIdxNext;
  logic [1:0]      ffRun;
  logic            hdrMatch;
  logic [7:0]      lowReg;
  logic [15:0]     mem [FRAMES][8];

  logic [PW-1:0]   wrPtr, rdPtr, rdPtrNext, heldSlot, heldSlotNext;
  logic            held, heldNext;
  logic [2:0]      wordIdx, wordIdxNext;
  logic [CW-1:0]   availCnt, availNext, usedCnt;
  logic [10:0]     stretch, stretchNext;

  logic byteStrobe, huntSync, hdrByteOk, rxSync, frameEnd;
  logic full, commit, drop, claim, memWrite;

  // ResyncReq wins over a byte arriving in the same cycle.
  assign byteStrobe = DataValid && !ResyncReq;

  // Three FFs seen (more are tolerated) followed by 7F while hunting.
  assign huntSync  = (state == HUNT) && byteStrobe && (DataIn == 8'h7F) && (ffRun == 2'd3);

  // Byte expected at frame positions 0..3 if the frame is really an inter-frame sync.
  assign hdrByteOk = (byteIdx == 4'd3) ? (DataIn == 8'h7F) : (DataIn == 8'hFF);
  assign rxSync    = (state == RX) && byteStrobe && (byteIdx == 4'd3) && hdrMatch && hdrByteOk;
  assign frameEnd  = (state == RX) && byteStrobe && (byteIdx == 4'hF);

  // Committed frames = held one plus unclaimed ones; judged on registered values,
  // so a release in the same cycle as a commit does not make room.
  assign usedCnt  = availCnt + CW'(held);
  assign full     = (usedCnt == CW'(FRAMES));
  assign commit   = frameEnd && !full;
  assign drop     = frameEnd && full;
  assign claim    = PacketNext && (availCnt != '0);

  // When full, the fill slot aliases a committed frame, so writes are held off
  // to keep the held and unclaimed frames intact.
  assign memWrite = (state == RX) && byteStrobe && byteIdx[0] && !full;

  assign InSync = (state == RX);

  // State and byte index register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= HUNT;
      byteIdx <= '0;
    end else begin
      state   <= stateNext;
      byteIdx <= byteIdxNext;
    end
  end

  // Next-state logic: sync hunt, frame byte counting, resync abort.
  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    stateNext   = state;
    byteIdxNext = byteIdx;
    if (ResyncReq) begin
      stateNext   = HUNT;
      byteIdxNext = '0;
    end else if (DataValid) begin
      case (state)
        HUNT: begin
          if (huntSync) begin
            stateNext   = RX;
            byteIdxNext = '0;
          end
        end
        RX: begin
          if (rxSync || frameEnd) byteIdxNext = '0;
          else                    byteIdxNext = byteIdx + 4'd1;
        end
        default: begin
          stateNext   = HUNT;
          byteIdxNext = '0;
        end
      endcase
    end
  end

  // Sync matcher: run length of consecutive FF bytes while hunting.
  always_ff @(posedge clk) begin
    if (!rst || ResyncReq || state == RX) begin
      ffRun <= '0;
    end else if (byteStrobe) begin
      if (DataIn == 8'hFF) ffRun <= (ffRun == 2'd3) ? 2'd3 : ffRun + 2'd1;
      else                 ffRun <= '0;
    end
  end

  // Tracks whether frame bytes 0..2 so far are FF (candidate inter-frame sync).
  always_ff @(posedge clk) begin
    if (!rst || ResyncReq || huntSync) begin
      hdrMatch <= 1'b1;
    end else if ((state == RX) && byteStrobe) begin
      if (rxSync || frameEnd)   hdrMatch <= 1'b1;
      else if (byteIdx < 4'd3)  hdrMatch <= hdrMatch && hdrByteOk;
    end
  end

  // Low byte of the word under construction (even frame positions).
  always_ff @(posedge clk) begin
    if (!rst) begin
      lowReg <= '0;
    end else if ((state == RX) && byteStrobe && !byteIdx[0]) begin
      lowReg <= DataIn;
    end
  end

  // Frame storage write on every odd byte.
  // NOTE: the frame memory is deliberately not reset; only slots that a
  // reader can reach after a commit are ever read, and skipping the reset
  // keeps it mappable onto RAM.
  always_ff @(posedge clk) begin
    if (memWrite) mem[wrPtr][byteIdx[3:1]] <= {DataIn, lowReg};
  end

  // Read-side next values: release/claim on PacketNext, word stepping on PacketNextWd.
  always_comb begin
    heldNext     = held;
    heldSlotNext = heldSlot;
    rdPtrNext    = rdPtr;
    wordIdxNext  = wordIdx;
    if (PacketNext) begin
      wordIdxNext = '0;
      if (claim) begin
        heldNext     = 1'b1;
        heldSlotNext = rdPtr;
        rdPtrNext    = rdPtr + PW'(1);
      end else begin
        heldNext = 1'b0;
      end
    end else if (PacketNextWd && held) begin
      wordIdxNext = wordIdx + 3'd1;
    end
    availNext = availCnt + CW'(commit) - CW'(claim);
  end

  // Buffer pointers, held frame and registered reader outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      heldSlot    <= '0;
      held        <= 1'b0;
      wordIdx     <= '0;
      availCnt    <= '0;
      PacketAvail <= 1'b0;
      PacketOut   <= '0;
    end else begin
      if (commit) wrPtr <= wrPtr + PW'(1);
      rdPtr       <= rdPtrNext;
      heldSlot    <= heldSlotNext;
      held        <= heldNext;
      wordIdx     <= wordIdxNext;
      availCnt    <= availNext;
      PacketAvail <= (availNext != '0);
      PacketOut   <= heldNext ? mem[heldSlotNext][wordIdxNext] : 16'h0000;
    end
  end

  // Overflow stretch counter: reloaded on each drop, counts down to zero.
  always_comb begin
    stretchNext = stretch;
    if (drop)                stretchNext = 11'(OVF_STRETCH);
    else if (stretch != '0)  stretchNext = stretch - 11'd1;
  end

  // Registered overflow indicator.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stretch  <= '0;
      Overflow <= 1'b0;
    end else begin
      stretch  <= stretchNext;
      Overflow <= (stretchNext != '0);
    end
  end

`ifdef PACK_RECV_STATS_EN
  // Saturating statistics counters for drops and recognised sync sequences.
  always_ff @(posedge clk) begin
    if (!rst) begin
      DropCount <= '0;
      SyncCount <= '0;
    end else begin
      if (drop && (DropCount != 16'hFFFF))
        DropCount <= DropCount + 16'd1;
      if ((huntSync || rxSync) && (SyncCount != 16'hFFFF))
        SyncCount <= SyncCount + 16'd1;
    end
  end
`else
  assign DropCount = 16'h0000;
  assign SyncCount = 16'h0000;
`endif

endmodule
